// File: rtl/let_division_apply_if.sv
// Bus for the divisionApply execution unit: control, argument and
// region signals between the ex stage and the divide block.
interface let_division_apply_if #(
  parameter int unsigned AW     = 8,
  parameter int unsigned NWORDS = 16
);
  logic                   start_i;
  logic [AW-1:0]          dest_i;
  logic [AW-1:0]          src_i;
  logic [AW-1:0]          len_i;
  logic [NWORDS*32-1:0]   thread_i;
  logic [NWORDS*32-1:0]   data_i;
  logic [NWORDS*32-1:0]   shared_i;
  logic                   busy_o;
  logic                   done_o;
  logic [NWORDS*32-1:0]   thread_o;
  logic [NWORDS*32-1:0]   data_o;
  logic [NWORDS*32-1:0]   shared_o;

  modport master (
    output start_i, dest_i, src_i, len_i,
    output thread_i, data_i, shared_i,
    input  busy_o, done_o,
    input  thread_o, data_o, shared_o
  );

  modport slave (
    input  start_i, dest_i, src_i, len_i,
    input  thread_i, data_i, shared_i,
    output busy_o, done_o,
    output thread_o, data_o, shared_o
  );
endinterface

// File: rtl/let_division_apply.sv
// divisionApply: divides a run of ex_ev words by one signed divisor,
// one lane per clock, and returns the updated thread/data/shared regions.
module let_division_apply #(
  parameter int unsigned NWORDS      = 16,
  parameter int unsigned THREAD_BASE = 0,
  parameter int unsigned DATA_BASE   = 16,
  parameter int unsigned SHARED_BASE = 32,
  parameter int unsigned AW          = 8
) (
  input  logic clk,
  input  logic rst_n,
  let_division_apply_if.slave bus
);

  localparam int unsigned IW = $clog2(NWORDS);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned RW = NWORDS * 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic          hit;
    logic [1:0]    rsel;
    logic [IW-1:0] idx;
  } loc_t;

  // Offsets wrap when a < base, so one unsigned compare covers both bounds
  function automatic loc_t decode(input logic [AW-1:0] a);
    int unsigned av;
    loc_t        l;
    av = 32'(a);
    l  = '0;
    unique case (1'b1)
      (av - THREAD_BASE < NWORDS): begin
        l.hit  = 1'b1;
        l.rsel = 2'd0;
        l.idx  = IW'(av - THREAD_BASE);
      end
      (av - DATA_BASE < NWORDS): begin
        l.hit  = 1'b1;
        l.rsel = 2'd1;
        l.idx  = IW'(av - DATA_BASE);
      end
      (av - SHARED_BASE < NWORDS): begin
        l.hit  = 1'b1;
        l.rsel = 2'd2;
        l.idx  = IW'(av - SHARED_BASE);
      end
      default: l = '0;
    endcase
    return l;
  endfunction

  function automatic logic [31:0] pick(
    input logic [RW-1:0] v,
    input logic [IW-1:0] i
  );
    return v[{i, 5'd0} +: 32];
  endfunction

  function automatic logic [31:0] sdiv(
    input logic [31:0] n,
    input logic [31:0] d
  );
    logic [31:0] q;
    if (d == '0)
      q = '1;
    else if (n == 32'h8000_0000 && d == '1)
      q = n;
    else
      q = 32'($signed(n) / $signed(d));
    return q;
  endfunction

  state_t        st;
  logic [31:0]   thr_w [NWORDS];
  logic [31:0]   dat_w [NWORDS];
  logic [31:0]   shr_w [NWORDS];
  logic [31:0]   divisor;
  logic [1:0]    rsel;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  loc_t          dl;
  loc_t          sl;
  logic [31:0]   div_in;
  int unsigned   room;
  int unsigned   lenv;
  logic [CW-1:0] eff;
  logic [31:0]   cur;
  logic [31:0]   quo;

  // Divisor comes from the input regions, before any lane is rewritten
  always_comb begin
    dl   = decode(bus.dest_i);
    sl   = decode(bus.src_i);
    room = NWORDS - 32'(dl.idx);
    lenv = 32'(bus.len_i);
    eff  = '0;
    unique case (sl.rsel)
      2'd0:    div_in = pick(bus.thread_i, sl.idx);
      2'd1:    div_in = pick(bus.data_i, sl.idx);
      default: div_in = pick(bus.shared_i, sl.idx);
    endcase
    if (dl.hit && sl.hit)
      eff = CW'(lenv < room ? lenv : room);
  end

  always_comb begin
    unique case (rsel)
      2'd0:    cur = thr_w[ptr];
      2'd1:    cur = dat_w[ptr];
      default: cur = shr_w[ptr];
    endcase
    quo = sdiv(cur, divisor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      bus.busy_o   <= 1'b0;
      bus.done_o   <= 1'b0;
      bus.thread_o <= '0;
      bus.data_o   <= '0;
      bus.shared_o <= '0;
      divisor      <= '0;
      rsel         <= '0;
      ptr          <= '0;
      cnt          <= '0;
      for (int k = 0; k < NWORDS; k++) begin
        thr_w[k] <= '0;
        dat_w[k] <= '0;
        shr_w[k] <= '0;
      end
    end else begin
      bus.done_o <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.start_i) begin
            for (int k = 0; k < NWORDS; k++) begin
              thr_w[k] <= pick(bus.thread_i, IW'(k));
              dat_w[k] <= pick(bus.data_i, IW'(k));
              shr_w[k] <= pick(bus.shared_i, IW'(k));
            end
            divisor    <= div_in;
            rsel       <= dl.rsel;
            ptr        <= dl.idx;
            cnt        <= eff;
            bus.busy_o <= 1'b1;
            st         <= (eff == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          unique case (rsel)
            2'd0:    thr_w[ptr] <= quo;
            2'd1:    dat_w[ptr] <= quo;
            default: shr_w[ptr] <= quo;
          endcase
          ptr <= ptr + 1'b1;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            st <= DONE;
        end
        DONE: begin
          for (int k = 0; k < NWORDS; k++) begin
            bus.thread_o[k*32 +: 32] <= thr_w[k];
            bus.data_o[k*32 +: 32]   <= dat_w[k];
            bus.shared_o[k*32 +: 32] <= shr_w[k];
          end
          bus.done_o <= 1'b1;
          bus.busy_o <= 1'b0;
          st         <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_let_division_apply.sv
// Directed vector bench for let_division_apply: regions, latency,
// handshake pulses, ignored restart and mid-run reset.
module tb_let_division_apply;

  localparam int AW = 8;
  localparam int NW = 16;

  typedef struct {
    logic [AW-1:0]  dest;
    logic [AW-1:0]  src;
    logic [AW-1:0]  len;
    logic [511:0]   thr;
    logic [511:0]   dat;
    logic [511:0]   shr;
    logic [511:0]   e_thr;
    logic [511:0]   e_dat;
    logic [511:0]   e_shr;
    int             lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  vec_t v [11];

  let_division_apply_if #(.AW(AW), .NWORDS(NW)) bus ();

  let_division_apply dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] pk(
    int a0 = 0, int a1 = 0, int a2 = 0, int a3 = 0, int a4 = 0,
    int a5 = 0, int a6 = 0, int a7 = 0, int a8 = 0
  );
    logic [511:0] r;
    r = '0;
    r[31:0]    = a0;
    r[63:32]   = a1;
    r[95:64]   = a2;
    r[127:96]  = a3;
    r[159:128] = a4;
    r[191:160] = a5;
    r[223:192] = a6;
    r[255:224] = a7;
    r[287:256] = a8;
    return r;
  endfunction

  function automatic logic [511:0] sw(
    logic [511:0] r, int i, logic [31:0] w
  );
    r[i*32 +: 32] = w;
    return r;
  endfunction

  task automatic cmp(
    input string nm, input int idx,
    input logic [511:0] got, input logic [511:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s v%0d got %h want %h", nm, idx, got, exp);
    end
  endtask

  task automatic setv(
    input int i, input int d, input int s, input int l,
    input logic [511:0] t, input logic [511:0] da,
    input logic [511:0] sh, input int lat
  );
    v[i].dest  = AW'(d);
    v[i].src   = AW'(s);
    v[i].len   = AW'(l);
    v[i].thr   = t;
    v[i].dat   = da;
    v[i].shr   = sh;
    v[i].e_thr = t;
    v[i].e_dat = da;
    v[i].e_shr = sh;
    v[i].lat   = lat;
  endtask

  // poke >= 0 re-asserts start with junk inputs that many cycles in
  task automatic run(input int i, input int poke);
    int   n;
    logic got;
    @(negedge clk);
    bus.dest_i   = v[i].dest;
    bus.src_i    = v[i].src;
    bus.len_i    = v[i].len;
    bus.thread_i = v[i].thr;
    bus.data_i   = v[i].dat;
    bus.shared_i = v[i].shr;
    bus.start_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    cmp("busy_start", i, 512'(bus.busy_o), 512'(1));
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      if (n == poke) begin
        bus.dest_i  = 8'd16;
        bus.src_i   = 8'd32;
        bus.len_i   = 8'd0;
        bus.data_i  = '0;
        bus.start_i = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      n++;
      if (bus.done_o) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout v%0d got none want %0d", i, v[i].lat);
    end else begin
      cmp("latency", i, 512'(n), 512'(v[i].lat));
    end
    cmp("thread", i, bus.thread_o, v[i].e_thr);
    cmp("data", i, bus.data_o, v[i].e_dat);
    cmp("shared", i, bus.shared_o, v[i].e_shr);
    @(posedge clk);
    #1;
    cmp("done_pulse", i, 512'(bus.done_o), 512'(0));
    cmp("busy_end", i, 512'(bus.busy_o), 512'(0));
  endtask

  initial begin
    logic [511:0] dd;
    logic [511:0] ss;
    logic [511:0] t;
    int           cnt;
    tests = 0;
    fails = 0;

    dd = pk(-67, -15, -24, 47, 26, 186, -255, 34567, 54);
    ss = pk(10, -35);

    setv(0, 16, 16, 2, pk(5, 6), pk(10, 11, 12, 13), pk(7), 3);
    v[0].e_dat = pk(1, 1, 12, 13);
    setv(1, 16, 32, 8, pk(9), dd, ss, 9);
    v[1].e_dat = pk(-6, -1, -2, 4, 2, 18, -25, 3456, 54);
    setv(2, 16, 33, 8, pk(9), dd, ss, 9);
    v[2].e_dat = pk(1, 0, 0, -1, 0, -5, 7, -987, 54);
    setv(3, 16, 34, 1, '0, pk(123, 5), ss, 2);
    v[3].e_dat = pk(-1, 5);
    t = sw(sw('0, 3, 32'h8000_0000), 4, 32'hFFFF_FFFF);
    setv(4, 3, 4, 1, t, pk(1), '0, 2);
    setv(5, 16, 32, 0, pk(3), dd, ss, 1);
    t = sw(sw(sw('0, 13, 32'd9), 14, 32'd100), 15, -32'sd7);
    setv(6, 46, 16, 5, '0, pk(2), t, 3);
    v[6].e_shr = sw(sw(sw('0, 13, 32'd9), 14, 32'd50), 15, -32'sd3);
    setv(7, 60, 32, 4, pk(4), dd, ss, 1);
    setv(8, 16, 200, 4, pk(4), dd, ss, 1);
    setv(9, 1, 0, 2, pk(7, -100, 50), pk(8), pk(9), 3);
    v[9].e_thr = pk(7, -14, 7);
    setv(10, 16, 17, 4, '0, pk(100, 50, 20, 10), '0, 5);
    v[10].e_dat = pk(2, 1, 0, 0);

    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.dest_i   = '0;
    bus.src_i    = '0;
    bus.len_i    = '0;
    bus.thread_i = '0;
    bus.data_i   = '0;
    bus.shared_i = '0;
    #13;
    cmp("rst_busy", 0, 512'(bus.busy_o), 512'(0));
    cmp("rst_done", 0, 512'(bus.done_o), 512'(0));
    cmp("rst_data", 0, bus.data_o, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run(i, -1);

    run(1, 3);

    @(negedge clk);
    bus.dest_i   = v[2].dest;
    bus.src_i    = v[2].src;
    bus.len_i    = v[2].len;
    bus.thread_i = v[2].thr;
    bus.data_i   = v[2].dat;
    bus.shared_i = v[2].shr;
    bus.start_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("abort_busy", 2, 512'(bus.busy_o), 512'(0));
    cmp("abort_done", 2, 512'(bus.done_o), 512'(0));
    cmp("abort_thread", 2, bus.thread_o, '0);
    cmp("abort_data", 2, bus.data_o, '0);
    cmp("abort_shared", 2, bus.shared_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done_o || bus.busy_o) cnt++;
    end
    cmp("abort_quiet", 2, 512'(cnt), 512'(0));

    run(0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
